// File: rtl/lsu_mem_port.sv
// lsu_mem_port: core load/store requests to a req/ack word bus with timeout and load extension.
module lsu_mem_port #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic [1:0]  o_resp_error,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;
  state_t      r_state, w_next;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [7:0]  r_cnt;
  logic        w_accept, w_illegal, w_misal, w_expire;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_ldata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign o_req_ready = r_state == S_IDLE;
  assign w_accept    = o_req_ready && i_req_valid;
  assign w_expire    = r_cnt == 8'(TIMEOUT_CYCLES - 1);
  assign w_illegal   = i_req_write ? (i_req_funct3 > 3'b010)
                                   : (i_req_funct3 == 3'b011 || i_req_funct3[2:1] == 2'b11);
  assign w_misal     = (i_req_funct3[1:0] == 2'b01 && i_req_addr[0]) ||
                       (i_req_funct3[1:0] == 2'b10 && i_req_addr[1:0] != 2'b00);
  assign w_wstrb     = i_req_funct3[1:0] == 2'b00 ? 4'b0001 << i_req_addr[1:0] :
                       i_req_funct3[1:0] == 2'b01 ? (i_req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata     = i_req_funct3[1:0] == 2'b00 ? {4{i_req_wdata[7:0]}} :
                       i_req_funct3[1:0] == 2'b01 ? {2{i_req_wdata[15:0]}} : i_req_wdata;
  assign w_byte      = r_lane[1] ? (r_lane[0] ? i_mem_rdata[31:24] : i_mem_rdata[23:16])
                                 : (r_lane[0] ? i_mem_rdata[15:8]  : i_mem_rdata[7:0]);
  assign w_half      = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
  // funct3[2] marks the unsigned variants, so it suppresses sign extension
  assign w_ldata     = r_funct3[1:0] == 2'b00 ? {{24{~r_funct3[2] & w_byte[7]}}, w_byte} :
                       r_funct3[1:0] == 2'b01 ? {{16{~r_funct3[2] & w_half[15]}}, w_half} : i_mem_rdata;

  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = (w_illegal || w_misal) ? S_RESP : S_BUS;
    else if (r_state == S_BUS && (i_mem_ack || w_expire)) w_next = S_RESP;
    else if (r_state == S_RESP) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_funct3     <= 3'b000;
      r_lane       <= 2'b00;
      r_cnt        <= 8'd0;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= 32'd0;
      o_resp_error <= 2'b00;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= 32'd0;
      o_mem_wstrb  <= 4'b0000;
      o_mem_wdata  <= 32'd0;
    end else begin
      r_state      <= w_next;
      o_mem_req    <= w_next == S_BUS;
      o_resp_valid <= w_next == S_RESP;
      r_cnt        <= (r_state == S_BUS && w_next == S_BUS) ? r_cnt + 8'd1 : 8'd0;
      if (w_accept) begin
        r_write  <= i_req_write;
        r_funct3 <= i_req_funct3;
        r_lane   <= i_req_addr[1:0];
      end
      if (w_accept && w_next == S_BUS) begin
        o_mem_we    <= i_req_write;
        o_mem_addr  <= {i_req_addr[31:2], 2'b00};
        o_mem_wstrb <= i_req_write ? w_wstrb : 4'b0000;
        o_mem_wdata <= w_wdata;
      end else if (w_next != S_BUS) begin
        o_mem_we    <= 1'b0;
        o_mem_wstrb <= 4'b0000;
      end
      if (w_next == S_RESP) begin
        o_resp_error <= r_state == S_IDLE ? (w_illegal ? 2'b10 : 2'b01) : (i_mem_ack ? 2'b00 : 2'b11);
        o_resp_rdata <= (r_state == S_BUS && i_mem_ack && !r_write) ? w_ldata : 32'd0;
      end
    end
  end
endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit between the single-cycle core's load/store datapath and the data memory bus. It accepts one byte, halfword or word access per request via a valid/ready handshake. It produces aligned word addresses, byte strobes and replicated write data, and runs a req/ack handshake with timeout to the memory. It returns sign- or zero-extended load data, or an error code, to the core.

## Interface
- TIMEOUT_CYCLES, 64, maximum number of cycles mem_req is held without mem_ack; range 2..255
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- req_valid  in  1  core presents an access
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bytes used for SB/SH
- resp_valid  out  1  one-cycle pulse, response fields valid
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout
- mem_req  out  1  bus request, held until ack or timeout
- mem_we  out  1  write access
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_wstrb  out  4  byte enables; 0000 for loads
- mem_wdata  out  32  replicated store data
- mem_ack  in  1  memory completes access in the cycle it is sampled high
- mem_rdata  in  32  read word, valid when mem_ack high

## Operation
- States: IDLE, BUS, RESP. Reset state IDLE.
- IDLE: req_ready=1. On req_valid at a rising edge, latch write, funct3, addr and wdata.
  - Illegal funct3 (load 011/110/111; store funct3 > 010) -> RESP, error 10.
  - Else misaligned (H: addr[0]!=0; W: addr[1:0]!=0) -> RESP, error 01.
  - Else -> BUS.
  - Illegal funct3 takes priority over misalignment. Errored accesses never assert mem_req.
- BUS: mem_req=1 with mem_we, mem_addr, mem_wstrb and mem_wdata stable for the whole state.
  - mem_ack sampled high -> capture formatted load data -> RESP, error 00.
  - Else timeout counter increments. When the counter reaches TIMEOUT_CYCLES-1 with no ack -> RESP, error 11.
  - An ack on the final cycle wins over timeout.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Store formatting:
  - SB: wdata={4{wdata[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{wdata[15:0]}}, wstrb=0011 (addr[1]=0) or 1100.
  - SW: wdata as given, wstrb=1111.
- Load extraction from mem_rdata:
  - LB/LBU: byte lane addr[1:0].
  - LH/LHU: halfword lane addr[1].
  - LW: whole word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Outside BUS: mem_req, mem_we and mem_wstrb are 0; mem_addr and mem_wdata hold their last values.
- mem_ack outside BUS (late or spurious) is ignored.
- req_valid while not IDLE is ignored. The core must hold the request until ready.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_error 00, mem_req 0, mem_we 0, mem_addr 0, mem_wstrb 0000, mem_wdata 0, timeout counter 0.
- All outputs except req_ready are registered. req_ready is decoded from state.
- Accept at edge E0 -> mem_req high in the cycle after E0. Ack sampled at edge Ek -> resp_valid high in the cycle after Ek -> req_ready high one cycle later.
- Minimum access: 3 cycles from accept to next accept; resp_valid follows accept by 2 edges.
- Error path: resp_valid in the cycle after the accept edge.
- Timeout: mem_req high for exactly TIMEOUT_CYCLES cycles.
- Counter clears on every entry to BUS.
- Reset asserted mid-access: mem_req drops asynchronously, no resp_valid is produced, and the in-flight access is abandoned.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, ack in the 3rd BUS cycle -> mem_req high 3 cycles, mem_addr 0x100, wstrb 1111, mem_we 1, then resp_valid 1 cycle with error 00 and rdata 0.
- mem_rdata 0x80FF1234 with:
  - LB 0x203 -> 0xFFFFFF80
  - LBU 0x203 -> 0x00000080
  - LH 0x202 -> 0xFFFF80FF
  - LHU 0x202 -> 0x000080FF
  - LW 0x200 -> 0x80FF1234
  - Each with 0-wait ack (resp_valid 2 edges after accept).
- Store formatting:
  - SB 0x101, wdata 0x000000AB -> mem_addr 0x100, wstrb 0010, mem_wdata 0xABABABAB.
  - SH 0x102, wdata 0x00001234 -> wstrb 1100, mem_wdata 0x12341234.
- Error codes:
  - LW 0x102 -> error 01.
  - Load funct3 011 at 0x100 -> error 10.
  - Store funct3 100 at 0x101 -> error 10.
  - For all: mem_req never high, resp_valid 1 edge after accept, rdata 0.
- TIMEOUT_CYCLES=8, no ack -> mem_req high exactly 8 cycles, error 11. A later mem_ack pulse in IDLE causes no resp_valid.
- reset driven low during BUS cycle 2 -> mem_req 0 immediately, req_ready 1. After release, a new LW at 0x0 completes normally.
